ccip_host_mem_responder: RTL and testbench

- Host/FIU-side responder model for the CCI request interface that AFUs drive.
- Accepts c0 read requests and c1 write requests on flat ports and services them from an internal line-wide memory.
- Returns c0 read-data and c1 write-ack responses after a programmable latency and drives the per-channel almost-full back-pressure.
- Used as the far end of the AFU request path in standalone simulation and FPGA loopback builds.

---
 rtl/ccip_host_mem_responder.sv | 205 ++++++++++++++++++++
 tb/tb_ccip_host_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_host_mem_responder.sv
// Host-side CCI responder: queues c0 reads and c1 writes, answers them from a line-wide
// memory after a programmable minimum latency, and drives per-channel almost-full.
module ccip_host_mem_responder #(
  parameter int unsigned ADDR_W          = 42,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned MDATA_W         = 16,
  parameter int unsigned MEM_LINES       = 256,
  parameter int unsigned RD_LAT          = 4,
  parameter int unsigned WR_LAT          = 2,
  parameter int unsigned QDEPTH          = 8,
  parameter int unsigned ALM_FULL_THRESH = 2
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               c0_req_valid_i,
  input  logic [ADDR_W-1:0]  c0_req_addr_i,
  input  logic [MDATA_W-1:0] c0_req_mdata_i,
  input  logic               c1_req_valid_i,
  input  logic [ADDR_W-1:0]  c1_req_addr_i,
  input  logic [MDATA_W-1:0] c1_req_mdata_i,
  input  logic [DATA_W-1:0]  c1_req_data_i,
  output logic               c0_rsp_valid_o,
  output logic [MDATA_W-1:0] c0_rsp_mdata_o,
  output logic [DATA_W-1:0]  c0_rsp_data_o,
  output logic               c1_rsp_valid_o,
  output logic [MDATA_W-1:0] c1_rsp_mdata_o,
  output logic               c0_alm_full_o,
  output logic               c1_alm_full_o,
  output logic [1:0]         err_overflow_o
);

  localparam int unsigned IdxW = $clog2(MEM_LINES);
  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [7:0]      RdAgeMin = 8'(RD_LAT - 1);
  localparam logic [7:0]      WrAgeMin = 8'(WR_LAT - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(QDEPTH);

  // Free-running timestamp; ages are taken modulo 256 so wrap-around is harmless.
  logic [7:0] ts_q, ts_d;

  logic [DATA_W-1:0] mem_q [MEM_LINES];

  logic [IdxW-1:0] c0_req_idx;
  logic [IdxW-1:0] c1_req_idx;
  logic            unused_addr_hi;

  assign c0_req_idx     = c0_req_addr_i[IdxW-1:0];
  assign c1_req_idx     = c1_req_addr_i[IdxW-1:0];
  assign unused_addr_hi = ^{c0_req_addr_i[ADDR_W-1:IdxW], c1_req_addr_i[ADDR_W-1:IdxW]};

  // c0 (read) queue
  logic [IdxW-1:0]    c0_idx_q [QDEPTH];
  logic [MDATA_W-1:0] c0_tag_q [QDEPTH];
  logic [7:0]         c0_ts_q  [QDEPTH];
  logic [PtrW-1:0]    c0_wptr_q, c0_wptr_d;
  logic [PtrW-1:0]    c0_rptr_q, c0_rptr_d;
  logic [CntW-1:0]    c0_cnt_q, c0_cnt_d;
  logic [7:0]         c0_age;
  logic [IdxW-1:0]    c0_head_idx;
  logic               c0_push, c0_pop, c0_ovf;

  // c1 (write-ack) queue
  logic [MDATA_W-1:0] c1_tag_q [QDEPTH];
  logic [7:0]         c1_ts_q  [QDEPTH];
  logic [PtrW-1:0]    c1_wptr_q, c1_wptr_d;
  logic [PtrW-1:0]    c1_rptr_q, c1_rptr_d;
  logic [CntW-1:0]    c1_cnt_q, c1_cnt_d;
  logic [7:0]         c1_age;
  logic               c1_push, c1_pop, c1_ovf;

  // Response registers
  logic               c0_rsp_valid_q, c0_rsp_valid_d;
  logic [MDATA_W-1:0] c0_rsp_mdata_q, c0_rsp_mdata_d;
  logic [DATA_W-1:0]  c0_rsp_data_q, c0_rsp_data_d;
  logic               c1_rsp_valid_q, c1_rsp_valid_d;
  logic [MDATA_W-1:0] c1_rsp_mdata_q, c1_rsp_mdata_d;
  logic [1:0]         err_q, err_d;
  logic [DATA_W-1:0]  c0_rd_data;

  assign ts_d = ts_q + 8'd1;

  assign c0_age      = ts_q - c0_ts_q[c0_rptr_q];
  assign c0_head_idx = c0_idx_q[c0_rptr_q];
  assign c0_pop      = (c0_cnt_q != '0) && (c0_age >= RdAgeMin);
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign c0_push     = c0_req_valid_i && ((c0_cnt_q != CntFull) || c0_pop);
  assign c0_ovf      = c0_req_valid_i && !c0_push;

  assign c1_age  = ts_q - c1_ts_q[c1_rptr_q];
  assign c1_pop  = (c1_cnt_q != '0) && (c1_age >= WrAgeMin);
  assign c1_push = c1_req_valid_i && ((c1_cnt_q != CntFull) || c1_pop);
  assign c1_ovf  = c1_req_valid_i && !c1_push;

  // A write accepted in the read's pop cycle must be visible, so bypass the array.
  assign c0_rd_data = (c1_push && (c1_req_idx == c0_head_idx)) ? c1_req_data_i
                                                                : mem_q[c0_head_idx];

  always_comb begin
    c0_wptr_d = c0_wptr_q;
    c0_rptr_d = c0_rptr_q;
    c0_cnt_d  = c0_cnt_q;
    if (c0_push) c0_wptr_d = c0_wptr_q + PtrW'(1);
    if (c0_pop)  c0_rptr_d = c0_rptr_q + PtrW'(1);
    unique case ({c0_push, c0_pop})
      2'b10:   c0_cnt_d = c0_cnt_q + CntW'(1);
      2'b01:   c0_cnt_d = c0_cnt_q - CntW'(1);
      default: c0_cnt_d = c0_cnt_q;
    endcase
  end

  always_comb begin
    c1_wptr_d = c1_wptr_q;
    c1_rptr_d = c1_rptr_q;
    c1_cnt_d  = c1_cnt_q;
    if (c1_push) c1_wptr_d = c1_wptr_q + PtrW'(1);
    if (c1_pop)  c1_rptr_d = c1_rptr_q + PtrW'(1);
    unique case ({c1_push, c1_pop})
      2'b10:   c1_cnt_d = c1_cnt_q + CntW'(1);
      2'b01:   c1_cnt_d = c1_cnt_q - CntW'(1);
      default: c1_cnt_d = c1_cnt_q;
    endcase
  end

  always_comb begin
    c0_rsp_valid_d = c0_pop;
    c0_rsp_mdata_d = '0;
    c0_rsp_data_d  = '0;
    c1_rsp_valid_d = c1_pop;
    c1_rsp_mdata_d = '0;
    if (c0_pop) begin
      c0_rsp_mdata_d = c0_tag_q[c0_rptr_q];
      c0_rsp_data_d  = c0_rd_data;
    end
    if (c1_pop) begin
      c1_rsp_mdata_d = c1_tag_q[c1_rptr_q];
    end
    err_d = err_q | {c1_ovf, c0_ovf};
  end

  // Memory and queue payloads carry no reset; only pointers and counts do.
  always_ff @(posedge clk_i) begin
    if (c1_push) begin
      mem_q[c1_req_idx]   <= c1_req_data_i;
      c1_tag_q[c1_wptr_q] <= c1_req_mdata_i;
      c1_ts_q[c1_wptr_q]  <= ts_q;
    end
    if (c0_push) begin
      c0_idx_q[c0_wptr_q] <= c0_req_idx;
      c0_tag_q[c0_wptr_q] <= c0_req_mdata_i;
      c0_ts_q[c0_wptr_q]  <= ts_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ts_q      <= '0;
      c0_wptr_q <= '0;
      c0_rptr_q <= '0;
      c0_cnt_q  <= '0;
      c1_wptr_q <= '0;
      c1_rptr_q <= '0;
      c1_cnt_q  <= '0;
    end else begin
      ts_q      <= ts_d;
      c0_wptr_q <= c0_wptr_d;
      c0_rptr_q <= c0_rptr_d;
      c0_cnt_q  <= c0_cnt_d;
      c1_wptr_q <= c1_wptr_d;
      c1_rptr_q <= c1_rptr_d;
      c1_cnt_q  <= c1_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      c0_rsp_valid_q <= 1'b0;
      c0_rsp_mdata_q <= '0;
      c0_rsp_data_q  <= '0;
      c1_rsp_valid_q <= 1'b0;
      c1_rsp_mdata_q <= '0;
      err_q          <= '0;
    end else begin
      c0_rsp_valid_q <= c0_rsp_valid_d;
      c0_rsp_mdata_q <= c0_rsp_mdata_d;
      c0_rsp_data_q  <= c0_rsp_data_d;
      c1_rsp_valid_q <= c1_rsp_valid_d;
      c1_rsp_mdata_q <= c1_rsp_mdata_d;
      err_q          <= err_d;
    end
  end

  assign c0_rsp_valid_o = c0_rsp_valid_q;
  assign c0_rsp_mdata_o = c0_rsp_mdata_q;
  assign c0_rsp_data_o  = c0_rsp_data_q;
  assign c1_rsp_valid_o = c1_rsp_valid_q;
  assign c1_rsp_mdata_o = c1_rsp_mdata_q;
  assign err_overflow_o = err_q;

  // Almost-full looks only at registered occupancy.
  assign c0_alm_full_o = (QDEPTH - 32'(c0_cnt_q)) <= ALM_FULL_THRESH;
  assign c1_alm_full_o = (QDEPTH - 32'(c1_cnt_q)) <= ALM_FULL_THRESH;

endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Bench for ccip_host_mem_responder: directed scenarios plus random traffic, checked
// against a response-schedule model (due cycle = max(accept + latency, previous due + 1)).
module tb_ccip_host_mem_responder;

  localparam int AW     = 42;
  localparam int DW     = 512;
  localparam int MW     = 16;
  localparam int QD     = 8;
  localparam int THR    = 2;
  localparam int RL     = 4;
  localparam int WL     = 2;
  localparam int OVF_RL = 200;

  logic          clk, rst_n;
  logic          c0v, c1v;
  logic [AW-1:0] c0a, c1a;
  logic [MW-1:0] c0m, c1m;
  logic [DW-1:0] c1d;
  logic          r0v, r1v;
  logic [MW-1:0] r0m, r1m;
  logic [DW-1:0] r0d;
  logic          alm0, alm1;
  logic [1:0]    err;

  logic          ov;
  logic [AW-1:0] oa;
  logic [MW-1:0] om;
  logic          o_r0v, o_r1v;
  logic [MW-1:0] o_r0m, o_r1m;
  logic [DW-1:0] o_r0d;
  logic          o_alm0, o_alm1;
  logic [1:0]    o_err;

  ccip_host_mem_responder dut (
    .clk_i(clk), .reset_ni(rst_n),
    .c0_req_valid_i(c0v), .c0_req_addr_i(c0a), .c0_req_mdata_i(c0m),
    .c1_req_valid_i(c1v), .c1_req_addr_i(c1a), .c1_req_mdata_i(c1m), .c1_req_data_i(c1d),
    .c0_rsp_valid_o(r0v), .c0_rsp_mdata_o(r0m), .c0_rsp_data_o(r0d),
    .c1_rsp_valid_o(r1v), .c1_rsp_mdata_o(r1m),
    .c0_alm_full_o(alm0), .c1_alm_full_o(alm1), .err_overflow_o(err)
  );

  ccip_host_mem_responder #(.RD_LAT(OVF_RL)) dut_ovf (
    .clk_i(clk), .reset_ni(rst_n),
    .c0_req_valid_i(ov), .c0_req_addr_i(oa), .c0_req_mdata_i(om),
    .c1_req_valid_i(1'b0), .c1_req_addr_i('0), .c1_req_mdata_i('0), .c1_req_data_i('0),
    .c0_rsp_valid_o(o_r0v), .c0_rsp_mdata_o(o_r0m), .c0_rsp_data_o(o_r0d),
    .c1_rsp_valid_o(o_r1v), .c1_rsp_mdata_o(o_r1m),
    .c0_alm_full_o(o_alm0), .c1_alm_full_o(o_alm1), .err_overflow_o(o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int            rsp;
    logic [MW-1:0] md;
    int            idx;
  } ent_t;

  ent_t          q0[$];
  ent_t          q1[$];
  logic [DW-1:0] mem_m [256];
  bit            known [256];
  bit [1:0]      err_m;
  int            n;
  int            n_checks;
  int            n_pass;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Random upper bits exercise aliasing; low index confined to a small span.
  function automatic logic [AW-1:0] rnd_addr(input int span);
    logic [63:0] t;
    t = {$urandom, $urandom};
    t[7:0] = 8'($urandom_range(span - 1));
    return t[AW-1:0];
  endfunction

  // Check this cycle's outputs against the model, then drive and account for new requests.
  task automatic cycle(input bit v0, input logic [AW-1:0] a0, input logic [MW-1:0] m0,
                       input bit v1, input logic [AW-1:0] a1, input logic [MW-1:0] m1,
                       input logic [DW-1:0] d1);
    ent_t e;
    bit   exp0, exp1;
    int   busy;
    exp0 = (q0.size() > 0) && (q0[0].rsp == n);
    check("c0_rsp_valid", DW'(r0v), DW'(exp0));
    if (exp0) begin
      e = q0.pop_front();
      check("c0_rsp_mdata", DW'(r0m), DW'(e.md));
      if (known[e.idx]) check("c0_rsp_data", r0d, mem_m[e.idx]);
    end
    exp1 = (q1.size() > 0) && (q1[0].rsp == n);
    check("c1_rsp_valid", DW'(r1v), DW'(exp1));
    if (exp1) begin
      e = q1.pop_front();
      check("c1_rsp_mdata", DW'(r1m), DW'(e.md));
    end
    check("c0_alm_full", DW'(alm0), DW'((QD - q0.size()) <= THR));
    check("c1_alm_full", DW'(alm1), DW'((QD - q1.size()) <= THR));
    check("err_overflow", DW'(err), DW'(err_m));

    c0v = v0; c0a = a0; c0m = m0;
    c1v = v1; c1a = a1; c1m = m1; c1d = d1;
    if (v0) begin
      busy = 0;
      foreach (q0[i]) if (q0[i].rsp > n + 1) busy++;
      if (busy < QD) begin
        e.rsp = (q0.size() > 0 && q0[$].rsp + 1 > n + RL) ? q0[$].rsp + 1 : n + RL;
        e.md  = m0;
        e.idx = int'(a0[7:0]);
        q0.push_back(e);
      end else err_m[0] = 1'b1;
    end
    if (v1) begin
      busy = 0;
      foreach (q1[i]) if (q1[i].rsp > n + 1) busy++;
      if (busy < QD) begin
        e.rsp = (q1.size() > 0 && q1[$].rsp + 1 > n + WL) ? q1[$].rsp + 1 : n + WL;
        e.md  = m1;
        e.idx = int'(a1[7:0]);
        q1.push_back(e);
        mem_m[e.idx] = d1;
        known[e.idx] = 1'b1;
      end else err_m[1] = 1'b1;
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int            s, k, occ, seen, p0, p1;
    n = 0; n_checks = 0; n_pass = 0; err_m = '0;
    rst_n = 1'b0;
    c0v = 1'b0; c0a = '0; c0m = '0; c1v = 1'b0; c1a = '0; c1m = '0; c1d = '0;
    ov = 1'b0; oa = '0; om = '0;

    // Reset held with random strobes: everything stays quiet.
    for (int i = 0; i < 4; i++) begin
      c0v = 1'($urandom); c0a = rnd_addr(256); c0m = 16'($urandom);
      c1v = 1'($urandom); c1a = rnd_addr(256); c1m = 16'($urandom); c1d = rnd_line();
      ov  = 1'($urandom); oa = rnd_addr(256); om = 16'($urandom);
      @(posedge clk);
      #1;
      check("rst_outputs", DW'({r0v, r1v, r0m, r1m, alm0, alm1, err}), '0);
      check("rst_rdata", r0d, '0);
      check("rst_ovf_outputs", DW'({o_r0v, o_alm0, o_err}), '0);
    end
    c0v = 1'b0; c1v = 1'b0; ov = 1'b0;
    rst_n = 1'b1;
    check("release_alm_err", DW'({alm0, alm1, err}), '0);
    for (int i = 0; i < 5; i++) idle();

    // Write then read of the same line with default latencies.
    d = {16{32'hA5A5_0001}};
    s = n;
    cycle(1'b0, '0, '0, 1'b1, 42'h5, 16'h0011, d);
    cycle(1'b1, 42'h5, 16'h0022, 1'b0, '0, '0, '0);
    check("wr_ack_at_T2", DW'({r1v, r1m}), DW'({1'b1, 16'h0011}));
    idle(); idle(); idle();
    check("rd_rsp_at_T5", DW'({r0v, r0m}), DW'({1'b1, 16'h0022}));
    check("rd_rsp_data", r0d, d);
    idle(); idle();

    // Fill, almost-full and overflow on the long-latency instance.
    s = n;
    for (int i = 0; i < 9; i++) begin
      check("ovf_fill_alm", DW'(o_alm0), DW'(i >= 6));
      check("ovf_fill_err", DW'(o_err), '0);
      ov = 1'b1; om = 16'(i); oa = rnd_addr(256);
      idle();
    end
    ov = 1'b0;
    check("ovf_err_set", DW'(o_err), DW'(2'b01));
    k = 0;
    for (int c = 9; c < OVF_RL + 15; c++) begin
      occ = 0;
      for (int i = 0; i < QD; i++) if (i < c && i + OVF_RL > c) occ++;
      check("ovf_drain_alm", DW'(o_alm0), DW'((QD - occ) <= THR));
      if (o_r0v) begin
        check("ovf_rsp_mdata", DW'(o_r0m), DW'(k));
        check("ovf_rsp_time", DW'(c), DW'(OVF_RL + k));
        k++;
      end
      idle();
    end
    check("ovf_rsp_count", DW'(k), DW'(QD));
    check("ovf_err_sticky", DW'(o_err), DW'(2'b01));

    // Same-cycle read/write with aliasing address: read sees the new line 3.
    d = rnd_line();
    cycle(1'b1, 42'h003, 16'h0033, 1'b1, 42'h103, 16'h0044, d);
    idle(); idle(); idle();
    check("alias_rd_valid", DW'({r0v, r0m}), DW'({1'b1, 16'h0033}));
    check("alias_rd_data", r0d, d);

    // Write accepted in the read's pop cycle is visible to it.
    d = rnd_line();
    cycle(1'b1, 42'h20, 16'h0077, 1'b0, '0, '0, '0);
    idle(); idle();
    cycle(1'b0, '0, '0, 1'b1, 42'h3_0000_0020, 16'h0078, d);
    check("pop_cycle_wr_data", r0d, d);

    // Concurrent responses on both channels.
    cycle(1'b1, 42'h7, 16'h0055, 1'b0, '0, '0, '0);
    idle();
    cycle(1'b0, '0, '0, 1'b1, 42'h9, 16'h0066, rnd_line());
    idle();
    check("concurrent_valid", DW'({r0v, r1v}), DW'(2'b11));
    idle(); idle();

    // Reset mid-flight drops pending reads.
    cycle(1'b1, 42'h1, 16'h0101, 1'b0, '0, '0, '0);
    cycle(1'b1, 42'h2, 16'h0102, 1'b0, '0, '0, '0);
    cycle(1'b1, 42'h3, 16'h0103, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", DW'({r0v, r1v, alm0, alm1, err, o_err}), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q0.delete(); q1.delete(); err_m = '0; n++;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (r0v) seen++;
      idle();
    end
    check("no_rsp_after_reset", DW'(seen), '0);
    cycle(1'b1, 42'h3, 16'h0BEE, 1'b0, '0, '0, '0);
    idle(); idle(); idle();
    check("post_reset_read", DW'({r0v, r0m}), DW'({1'b1, 16'h0BEE}));
    idle();

    // Random traffic against the model.
    for (int b = 0; b < 6; b++) begin
      p0 = int'($urandom_range(90, 10));
      p1 = int'($urandom_range(90, 10));
      for (int i = 0; i < 250; i++)
        cycle(int'($urandom_range(99)) < p0, rnd_addr(16), 16'($urandom),
              int'($urandom_range(99)) < p1, rnd_addr(16), 16'($urandom), rnd_line());
    end
    for (int i = 0; i < 12; i++) idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
